// File: rtl/alu_iterative_exec_if.sv
// Valid/ready operand and result channels of the iterative ALU.
// The master drives operands and accepts results; the slave is the execution unit.
interface alu_iterative_exec_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       alu_control;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             err;

  modport master (
    output in_valid, alu_control, a, b, out_ready,
    input  in_ready, out_valid, result, zero, err
  );

  modport slave (
    input  in_valid, alu_control, a, b, out_ready,
    output in_ready, out_valid, result, zero, err
  );
endinterface

// File: rtl/alu_iterative_exec.sv
// Multicycle ALU: logic/arithmetic ops finish in one cycle, shifts iterate one bit per cycle.
// Accepts operands in IDLE and holds the result in DONE until the consumer takes it.
module alu_iterative_exec #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input logic                 clk,
  input logic                 rst_n,
  alu_iterative_exec_if.slave bus
);

  localparam logic [3:0] OpAdd  = 4'b0000;
  localparam logic [3:0] OpSub  = 4'b0001;
  localparam logic [3:0] OpAnd  = 4'b0010;
  localparam logic [3:0] OpOr   = 4'b0011;
  localparam logic [3:0] OpSlt  = 4'b0101;
  localparam logic [3:0] OpPass = 4'b0111;
  localparam logic [3:0] OpSrl  = 4'b1000;
  localparam logic [3:0] OpSra  = 4'b1001;
  localparam logic [3:0] OpSll  = 4'b1010;
  localparam logic [3:0] OpXor  = 4'b1100;
  localparam logic [3:0] OpSltu = 4'b1101;

  localparam logic [SHAMT_W-1:0] CountOne = SHAMT_W'(1);

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  state_e             state_q, state_d;
  logic [3:0]         op_q, op_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [SHAMT_W-1:0] count_q, count_d;
  logic               zero_q, zero_d;
  logic               err_q, err_d;

  logic [WIDTH-1:0]   alu_res;
  logic               alu_legal;
  logic               is_shift;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   shift_next;
  logic               slt_res;
  logic               sltu_res;

  assign shamt    = bus.b[SHAMT_W-1:0];
  assign slt_res  = $signed(bus.a) < $signed(bus.b);
  assign sltu_res = bus.a < bus.b;

  // Single-cycle result for the incoming operands; shifts seed the accumulator with a.
  always_comb begin
    alu_res   = '0;
    alu_legal = 1'b1;
    is_shift  = 1'b0;
    case (bus.alu_control)
      OpAdd:  alu_res = bus.a + bus.b;
      OpSub:  alu_res = bus.a - bus.b;
      OpAnd:  alu_res = bus.a & bus.b;
      OpOr:   alu_res = bus.a | bus.b;
      OpXor:  alu_res = bus.a ^ bus.b;
      OpSlt:  alu_res = {{(WIDTH-1){1'b0}}, slt_res};
      OpSltu: alu_res = {{(WIDTH-1){1'b0}}, sltu_res};
      OpPass: alu_res = bus.b;
      OpSrl, OpSra, OpSll: begin
        is_shift = 1'b1;
        alu_res  = bus.a;
      end
      default: alu_legal = 1'b0;
    endcase
  end

  // One-bit step of the latched shift operation.
  always_comb begin
    case (op_q)
      OpSll:   shift_next = {acc_q[WIDTH-2:0], 1'b0};
      OpSra:   shift_next = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
      default: shift_next = {1'b0, acc_q[WIDTH-1:1]};
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    acc_d   = acc_q;
    count_d = count_q;
    zero_d  = zero_q;
    err_d   = err_q;
    case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          op_d   = bus.alu_control;
          err_d  = ~alu_legal;
          acc_d  = alu_res;
          zero_d = (alu_res == '0);
          if (is_shift && (shamt != '0)) begin
            count_d = shamt;
            state_d = StShift;
          end else begin
            state_d = StDone;
          end
        end
      end
      StShift: begin
        acc_d   = shift_next;
        count_d = count_q - CountOne;
        if (count_q == CountOne) begin
          zero_d  = (shift_next == '0);
          state_d = StDone;
        end
      end
      StDone: begin
        if (bus.out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      op_q    <= '0;
      acc_q   <= '0;
      count_q <= '0;
      zero_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      zero_q  <= zero_d;
      err_q   <= err_d;
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.result    = acc_q;
  assign bus.zero      = zero_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_alu_iterative_exec.sv
// Randomised bench for alu_iterative_exec against a plain-arithmetic reference model.
module tb_alu_iterative_exec;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_iterative_exec_if #(.WIDTH(32)) bus();

  alu_iterative_exec #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: result, err and cycles from accept to out_valid.
  function automatic void model(input logic [3:0] code, input logic [31:0] a,
                                input logic [31:0] b, output logic [31:0] res,
                                output logic err, output int lat);
    int sh;
    logic signed [31:0] sa;
    sh  = int'(b % 32);
    sa  = a;
    err = 1'b0;
    lat = 1;
    case (code)
      4'd0:  res = a + b;
      4'd1:  res = a - b;
      4'd2:  res = a & b;
      4'd3:  res = a | b;
      4'd5:  res = (sa < $signed(b)) ? 32'd1 : 32'd0;
      4'd7:  res = b;
      4'd8:  res = a >> sh;
      4'd9:  res = sa >>> sh;
      4'd10: res = a << sh;
      4'd12: res = a ^ b;
      4'd13: res = (a < b) ? 32'd1 : 32'd0;
      default: begin
        res = 32'd0;
        err = 1'b1;
      end
    endcase
    if ((code == 4'd8 || code == 4'd9 || code == 4'd10) && sh > 0) lat = sh + 1;
  endfunction

  task automatic junk();
    bus.in_valid    = 1'($urandom_range(0, 1));
    bus.alu_control = 4'($urandom);
    bus.a           = $urandom;
    bus.b           = $urandom;
  endtask

  // Called #1 after a rising edge with the unit idle; returns in the same phase.
  task automatic run_op(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b,
                        input int stall);
    logic [31:0] er;
    logic ee;
    int el;
    int cyc;
    model(code, a, b, er, ee, el);
    check_eq("idle_in_ready", 32'(bus.in_ready), 32'd1);
    bus.in_valid    = 1'b1;
    bus.alu_control = code;
    bus.a           = a;
    bus.b           = b;
    bus.out_ready   = 1'b0;
    @(posedge clk); #1;
    cyc = 1;
    while (!bus.out_valid && cyc < 64) begin
      check_eq("busy_in_ready", 32'(bus.in_ready), 32'd0);
      junk();
      @(posedge clk); #1;
      cyc++;
    end
    check_eq("latency", 32'(cyc), 32'(el));
    for (int i = 0; i < stall; i++) begin
      check_eq("hold_valid", 32'(bus.out_valid), 32'd1);
      check_eq("hold_in_ready", 32'(bus.in_ready), 32'd0);
      check_eq("hold_result", bus.result, er);
      junk();
      @(posedge clk); #1;
    end
    check_eq("result", bus.result, er);
    check_eq("zero", 32'(bus.zero), 32'(er == 32'd0));
    check_eq("err", 32'(bus.err), 32'(ee));
    check_eq("done_in_ready", 32'(bus.in_ready), 32'd0);
    bus.out_ready = 1'b1;
    junk();
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    check_eq("post_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("post_in_ready", 32'(bus.in_ready), 32'd1);
  endtask

  logic [3:0] legal_codes [11] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd5, 4'd7, 4'd8, 4'd9, 4'd10,
                                   4'd12, 4'd13};

  initial begin
    logic [3:0] code;
    bus.in_valid    = 1'b0;
    bus.alu_control = 4'd0;
    bus.a           = 32'd0;
    bus.b           = 32'd0;
    bus.out_ready   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("rst_result", bus.result, 32'd0);
    check_eq("rst_zero", 32'(bus.zero), 32'd0);
    check_eq("rst_err", 32'(bus.err), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(4'd0, 32'd5, 32'd7, 0);
    run_op(4'd1, 32'h1234, 32'h1234, 0);
    run_op(4'd5, 32'hFFFF_FFFF, 32'd1, 0);
    run_op(4'd13, 32'hFFFF_FFFF, 32'd1, 0);
    run_op(4'd9, 32'h8000_0000, 32'd4, 0);
    run_op(4'd8, 32'h8000_0000, 32'd4, 0);
    run_op(4'd10, 32'd1, 32'd31, 0);
    run_op(4'd0, 32'h0000_00FF, 32'h0000_0F00, 3);
    run_op(4'hF, 32'hDEAD_BEEF, 32'h1234_5678, 0);
    run_op(4'd8, 32'hCAFE_F00D, 32'd32, 1);
    run_op(4'd7, 32'h1111_1111, 32'hA5A5_5A5A, 2);

    // Reset mid-shift: SRL by 20, pulled after ten shift steps.
    bus.in_valid    = 1'b1;
    bus.alu_control = 4'd8;
    bus.a           = $urandom | 32'h8000_0000;
    bus.b           = 32'd20;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    check_eq("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("midrst_result", bus.result, 32'd0);
    check_eq("midrst_zero", 32'(bus.zero), 32'd0);
    check_eq("midrst_err", 32'(bus.err), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (12) begin
      @(posedge clk); #1;
      check_eq("midrst_no_result", 32'(bus.out_valid), 32'd0);
    end
    run_op(4'd0, 32'h7FFF_FFFF, 32'd1, 0);

    for (int n = 0; n < 150; n++) begin
      code = ($urandom_range(0, 7) == 0) ? 4'($urandom) : legal_codes[$urandom_range(0, 10)];
      run_op(code, $urandom, ($urandom_range(0, 5) == 0) ? $urandom : $urandom_range(0, 40),
             $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
